commit_fence_sequencer: RTL and testbench

// Sequences the side effects of FENCE, FENCE.I and SFENCE.VMA (plus external D$ flush requests) retiring on commit port 0.

---
 rtl/commit_fence_sequencer_pkg.sv | 24 ++
 rtl/commit_fence_sequencer.sv | 168 ++++++++++++++++
 tb/tb_commit_fence_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/commit_fence_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// commit_fence_sequencer_pkg
// Shared types and widths for the commit-stage fence sequencer.
//   fence_op_e       : kind of fence operation retiring on commit port 0
//   VLEN, ASID_WIDTH : widths of the SFENCE.VMA vaddr / asid operands
//   op_flushes_icache: FENCE.I and external D$ flush also invalidate the I$
// -----------------------------------------------------------------------------
package commit_fence_sequencer_pkg;

  localparam int VLEN       = 64;
  localparam int ASID_WIDTH = 16;

  typedef enum logic [1:0] {
    FOP_FENCE   = 2'd0,
    FOP_FENCE_I = 2'd1,
    FOP_SFENCE  = 2'd2,
    FOP_DFLUSH  = 2'd3
  } fence_op_e;

  function automatic logic op_flushes_icache(input fence_op_e op);
    return (op == FOP_FENCE_I) || (op == FOP_DFLUSH);
  endfunction

endpackage

// File: rtl/commit_fence_sequencer.sv
// -----------------------------------------------------------------------------
// commit_fence_sequencer
// Sequences the side effects of FENCE / FENCE.I / SFENCE.VMA / external D$
// flush requests retiring on commit port 0: drain store buffer, flush D$,
// invalidate I$ or flush TLB, flush pipeline, then pulse done_o.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   halt_i                debug halt, blocks acceptance of new requests
//   req_valid_i/op/vaddr/asid  request from commit port 0
//   req_ready_o           request accepted this cycle (IDLE and not halted)
//   no_st_pending_i       store buffer empty
//   dcache_flush_o        D$ flush request (level, held until ack)
//   dcache_flush_ack_i    one-cycle D$ flush done pulse
//   icache_flush_o        one-cycle I$ invalidate pulse
//   sfence_vma_o          one-cycle TLB flush pulse, with sfence_vaddr_o/asid_o
//   flush_pipe_o          one-cycle pipeline flush pulse
//   done_o                one-cycle completion pulse
//   busy_o                sequence in progress
//   timeout_o             sticky drain watchdog flag
// -----------------------------------------------------------------------------
module commit_fence_sequencer
  import commit_fence_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  halt_i,
  input  logic                  req_valid_i,
  input  fence_op_e             req_op_i,
  input  logic [VLEN-1:0]       req_vaddr_i,
  input  logic [ASID_WIDTH-1:0] req_asid_i,
  output logic                  req_ready_o,
  input  logic                  no_st_pending_i,
  output logic                  dcache_flush_o,
  input  logic                  dcache_flush_ack_i,
  output logic                  icache_flush_o,
  output logic                  sfence_vma_o,
  output logic [VLEN-1:0]       sfence_vaddr_o,
  output logic [ASID_WIDTH-1:0] sfence_asid_o,
  output logic                  flush_pipe_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  // A zero timeout disables the watchdog; keep the counter width legal anyway.
  localparam int CNT_W = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_DCFLUSH = 3'd2,
    ST_ICFLUSH = 3'd3,
    ST_TLB     = 3'd4,
    ST_PIPE    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  state_e                  state_reg, state_next;
  fence_op_e               op_reg;
  logic [VLEN-1:0]         vaddr_reg;
  logic [ASID_WIDTH-1:0]   asid_reg;
  logic                    accept;

  assign req_ready_o = (state_reg == ST_IDLE) && !halt_i;
  assign accept      = req_valid_i && req_ready_o;

  // State register and request operand capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      op_reg    <= FOP_FENCE;
      vaddr_reg <= '0;
      asid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg    <= req_op_i;
        vaddr_reg <= req_vaddr_i;
        asid_reg  <= req_asid_i;
      end
    end
  end

  // Next-state and Moore outputs. Each pulse output belongs to exactly one
  // state, so at most one of them can be high in any cycle.
  always_comb begin
    state_next     = state_reg;
    dcache_flush_o = 1'b0;
    icache_flush_o = 1'b0;
    sfence_vma_o   = 1'b0;
    flush_pipe_o   = 1'b0;
    done_o         = 1'b0;
    busy_o         = 1'b1;
    unique case (state_reg)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (accept) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Decision uses the registered op, so DRAIN always lasts >= 1 cycle.
        if (no_st_pending_i) begin
          state_next = (op_reg == FOP_SFENCE) ? ST_TLB : ST_DCFLUSH;
        end
      end
      ST_DCFLUSH: begin
        dcache_flush_o = 1'b1;
        if (dcache_flush_ack_i) begin
          state_next = op_flushes_icache(op_reg) ? ST_ICFLUSH : ST_PIPE;
        end
      end
      ST_ICFLUSH: begin
        icache_flush_o = 1'b1;
        state_next     = ST_PIPE;
      end
      ST_TLB: begin
        sfence_vma_o = 1'b1;
        state_next   = ST_PIPE;
      end
      ST_PIPE: begin
        flush_pipe_o = 1'b1;
        state_next   = ST_DONE;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign sfence_vaddr_o = vaddr_reg;
  assign sfence_asid_o  = asid_reg;

  // Drain watchdog: restarts on every request (DRAIN entry), counts DRAIN
  // cycles and saturates; the flag sets on the cycle the count reaches the
  // limit and only reset clears it. The FSM never aborts on timeout.
  generate
    if (DRAIN_TIMEOUT > 0) begin : g_wdog
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
      logic [CNT_W-1:0] cnt_reg;
      logic             timeout_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_reg     <= '0;
          timeout_reg <= 1'b0;
        end else if (accept) begin
          cnt_reg <= '0;
        end else if ((state_reg == ST_DRAIN) && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) timeout_reg <= 1'b1;
        end
      end

      assign timeout_o = timeout_reg;
    end else begin : g_no_wdog
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_commit_fence_sequencer.sv
module tb_commit_fence_sequencer;
  import commit_fence_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_ni;
  logic                  halt;
  logic                  req_valid;
  fence_op_e             req_op;
  logic [VLEN-1:0]       req_vaddr;
  logic [ASID_WIDTH-1:0] req_asid;
  logic                  req_ready_o;
  logic                  no_st_pending;
  logic                  dcache_flush_o;
  logic                  dcache_ack;
  logic                  icache_flush_o;
  logic                  sfence_vma_o;
  logic [VLEN-1:0]       sfence_vaddr_o;
  logic [ASID_WIDTH-1:0] sfence_asid_o;
  logic                  flush_pipe_o;
  logic                  done_o;
  logic                  busy_o;
  logic                  timeout_o;

  always #5 clk = ~clk;

  commit_fence_sequencer #(.DRAIN_TIMEOUT(16)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .halt_i             (halt),
    .req_valid_i        (req_valid),
    .req_op_i           (req_op),
    .req_vaddr_i        (req_vaddr),
    .req_asid_i         (req_asid),
    .req_ready_o        (req_ready_o),
    .no_st_pending_i    (no_st_pending),
    .dcache_flush_o     (dcache_flush_o),
    .dcache_flush_ack_i (dcache_ack),
    .icache_flush_o     (icache_flush_o),
    .sfence_vma_o       (sfence_vma_o),
    .sfence_vaddr_o     (sfence_vaddr_o),
    .sfence_asid_o      (sfence_asid_o),
    .flush_pipe_o       (flush_pipe_o),
    .done_o             (done_o),
    .busy_o             (busy_o),
    .timeout_o          (timeout_o)
  );

  // One stimulus record with its expected cycle numbers (accept cycle = 0).
  // drain: no_st_pending is low for cycles 0..drain-1.
  // ack_dly: D$ ack comes in the (ack_dly+1)-th cycle of dcache_flush_o.
  typedef struct {
    fence_op_e             op;
    logic [VLEN-1:0]       vaddr;
    logic [ASID_WIDTH-1:0] asid;
    int                    drain;
    int                    ack_dly;
    bit                    halt_mid;
    bit                    spur_ack;
    bit                    to_chk;
    int                    exp_dc_first;
    int                    exp_dc_cycles;
    int                    exp_ic;
    int                    exp_tlb;
    int                    exp_pipe;
    int                    exp_done;
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int dc_first = 0, dc_cycles = 0, ic = 0, ic_n = 0, tlb = 0, tlb_n = 0;
    int pipe = 0, done = 0, onehot_bad = 0;
    logic [VLEN-1:0] tv = '0;
    logic [ASID_WIDTH-1:0] ta = '0;
    bit got = 0;
    chk("ready_idle", 64'(req_ready_o), 64'd1);
    req_valid     = 1'b1;
    req_op        = v.op;
    req_vaddr     = v.vaddr;
    req_asid      = v.asid;
    no_st_pending = (v.drain == 0);
    dcache_ack    = 1'b0;
    sb.push_back(v);
    for (int k = 1; k <= 80 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        chk("busy_in_seq", 64'(busy_o), 64'd1);
        chk("ready_while_busy", 64'(req_ready_o), 64'd0);
      end
      if (dcache_flush_o) begin
        if (dc_first == 0) dc_first = k;
        dc_cycles++;
      end
      if (icache_flush_o) begin ic = k; ic_n++; end
      if (sfence_vma_o) begin tlb = k; tlb_n++; tv = sfence_vaddr_o; ta = sfence_asid_o; end
      if (flush_pipe_o) pipe = k;
      if ((int'(icache_flush_o) + int'(sfence_vma_o) + int'(flush_pipe_o) + int'(done_o)) > 1)
        onehot_bad++;
      if (v.to_chk && k == 16) chk("timeout_before_limit", 64'(timeout_o), 64'd0);
      if (v.to_chk && k == 17) chk("timeout_at_limit", 64'(timeout_o), 64'd1);
      if (done_o) begin done = k; got = 1; end
      // Inputs for this cycle, sampled at the coming edge.
      no_st_pending = (k >= v.drain);
      dcache_ack    = 1'b0;
      if (dcache_flush_o && dc_cycles == v.ack_dly + 1) dcache_ack = 1'b1;
      if (v.spur_ack && !dcache_flush_o && k < v.drain) dcache_ack = 1'b1;
      if (v.halt_mid && dcache_flush_o) halt = 1'b1;
      if (got) req_valid = 1'b0;
    end
    dcache_ack = 1'b0;
    halt       = 1'b0;
    req_valid  = 1'b0;
    if (!got) begin
      chk("done_within_budget", 64'd0, 64'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("done_cycle", 64'(done), 64'(e.exp_done));
      chk("pipe_cycle", 64'(pipe), 64'(e.exp_pipe));
      chk("dcache_first", 64'(dc_first), 64'(e.exp_dc_first));
      chk("dcache_cycles", 64'(dc_cycles), 64'(e.exp_dc_cycles));
      chk("icache_cycle", 64'(ic), 64'(e.exp_ic));
      chk("icache_count", 64'(ic_n), (e.exp_ic != 0) ? 64'd1 : 64'd0);
      chk("tlb_cycle", 64'(tlb), 64'(e.exp_tlb));
      chk("tlb_count", 64'(tlb_n), (e.exp_tlb != 0) ? 64'd1 : 64'd0);
      if (e.exp_tlb != 0) begin
        chk("sfence_vaddr", 64'(tv), 64'(e.vaddr));
        chk("sfence_asid", 64'(ta), 64'(e.asid));
      end
      chk("onehot_pulses", 64'(onehot_bad), 64'd0);
      if (e.to_chk) chk("timeout_sticky", 64'(timeout_o), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_done", 64'(busy_o), 64'd0);
    $display("txn %0d op=%s drain=%0d ack_dly=%0d dc_first=%0d dc_cycles=%0d ic=%0d tlb=%0d pipe=%0d done=%0d",
             idx, v.op.name(), v.drain, v.ack_dly, dc_first, dc_cycles, ic, tlb, pipe, done);
  endtask

  initial begin
    //           op           vaddr                   asid      dr ack hm sp to  dcf dcn ic tlb pipe done
    tbl[0] = '{FOP_FENCE,   64'h0,                  16'h0,     0, 0, 0, 0, 0,  2, 1,  0, 0,  3,  4};
    tbl[1] = '{FOP_FENCE,   64'h0,                  16'h0,     0, 2, 0, 0, 0,  2, 3,  0, 0,  5,  6};
    tbl[2] = '{FOP_FENCE_I, 64'h0,                  16'h0,    10, 0, 0, 1, 0, 11, 1, 12, 0, 13, 14};
    tbl[3] = '{FOP_SFENCE,  64'h8000_1000,          16'd5,     0, 0, 0, 0, 0,  0, 0,  0, 2,  3,  4};
    tbl[4] = '{FOP_FENCE_I, 64'h0,                  16'h0,     0, 0, 0, 0, 0,  2, 1,  3, 0,  4,  5};
    tbl[5] = '{FOP_DFLUSH,  64'h0,                  16'h0,     3, 1, 0, 0, 0,  4, 2,  6, 0,  7,  8};
    tbl[6] = '{FOP_FENCE,   64'h0,                  16'h0,     0, 3, 1, 0, 0,  2, 4,  0, 0,  6,  7};
    tbl[7] = '{FOP_SFENCE,  64'h0000_1234_5678_9abc, 16'hbeef,  5, 0, 0, 0, 0,  0, 0,  0, 6,  7,  8};
    tbl[8] = '{FOP_FENCE,   64'h0,                  16'h0,    40, 0, 0, 0, 1, 41, 1,  0, 0, 42, 43};

    rst_ni        = 1'b0;
    halt          = 1'b0;
    req_valid     = 1'b0;
    req_op        = FOP_FENCE;
    req_vaddr     = '0;
    req_asid      = '0;
    no_st_pending = 1'b1;
    dcache_ack    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_dcache", 64'(dcache_flush_o), 64'd0);
    chk("rst_pulses", 64'({icache_flush_o, sfence_vma_o, flush_pipe_o, done_o}), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_sfence_vaddr", 64'(sfence_vaddr_o), 64'd0);
    chk("rst_sfence_asid", 64'(sfence_asid_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready_o), 64'd1);

    // Halt in IDLE blocks acceptance.
    halt      = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("halt_ready_low", 64'(req_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("halt_no_accept", 64'(busy_o), 64'd0);
    halt      = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);
    chk("no_timeout_short_drains", 64'(timeout_o), 64'd0);
    run_vec(tbl[8], 8);

    // Reset asserted while the D$ flush is outstanding.
    req_valid     = 1'b1;
    req_op        = FOP_FENCE;
    no_st_pending = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_dcflush", 64'(dcache_flush_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("abort_dcache_drop", 64'(dcache_flush_o), 64'd0);
    chk("abort_busy_drop", 64'(busy_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_all_outputs",
        64'({dcache_flush_o, icache_flush_o, sfence_vma_o, flush_pipe_o, done_o, busy_o, timeout_o}),
        64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    run_vec(tbl[0], 9);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
